time_mode_ctrl: RTL

Mode and timekeeping controller that sequences the FND display path of the stopwatch/watch design. It owns a stopwatch (run/stop/clear FSM) and a free-running watch, both in hour/min/sec/centisecond format. It selects which time is packed onto the 24-bit display bus and drives the hour:min vs sec:csec page select. Button inputs arrive as debounced single-cycle pulses; outputs feed the FND controller directly.

---
 rtl/time_mode_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/time_mode_ctrl.sv
// Stopwatch/watch timekeeping and FND display source selection.
// Ports: clk, reset (sync, active-high), btn_run_stop/btn_clear/btn_mode/
// btn_disp (1-cycle pulses) -> fnd_in_data[23:0] {hh,mm,ss,cc},
// sel_display, mode, sw_state[1:0]. Optional: `define SPLIT_EN.
module time_mode_ctrl #(
  parameter int TICK_DIV        = 1_000_000,
  parameter int WATCH_INIT_HOUR = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_run_stop,
  input  logic        btn_clear,
  input  logic        btn_mode,
  input  logic        btn_disp,
  output logic [23:0] fnd_in_data,
  output logic        sel_display,
  output logic        mode,
  output logic [1:0]  sw_state
);

  localparam int DW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STOP = 2'b10
  } sw_st_t;

  // Packed {hour[4:0], min[5:0], sec[5:0], csec[6:0]} increment.
  // All carries ripple within the same call.
  function automatic logic [23:0] tc_inc(
    input logic [23:0] t
  );
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [6:0] c;
    {h, m, s, c} = t;
    if (c == 7'd99) begin
      c = 7'd0;
      if (s == 6'd59) begin
        s = 6'd0;
        if (m == 6'd59) begin
          m = 6'd0;
          h = (h == 5'd23) ? 5'd0 : h + 5'd1;
        end else begin
          m = m + 6'd1;
        end
      end else begin
        s = s + 6'd1;
      end
    end else begin
      c = c + 7'd1;
    end
    return {h, m, s, c};
  endfunction

  logic [DW-1:0] div_cnt;
  logic          tick;
  logic [23:0]   watch;
  logic [23:0]   sw_cnt;
  logic [23:0]   sw_disp;
  sw_st_t        state;
  logic          rs;
  logic          clr;

  assign tick = (div_cnt == DW'(TICK_DIV - 1));

  // Stopwatch buttons only act in stopwatch mode; run/stop beats clear.
  assign rs  = btn_run_stop & ~mode;
  assign clr = btn_clear & ~mode & ~btn_run_stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      watch <= {5'(WATCH_INIT_HOUR), 19'd0};
    end else if (tick) begin
      watch <= tc_inc(watch);
    end
  end

  // Pre-edge state decides whether a coincident tick counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sw_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          sw_cnt <= '0;
          if (rs) state <= RUN;
        end
        RUN: begin
          if (tick) sw_cnt <= tc_inc(sw_cnt);
          if (rs) state <= STOP;
        end
        STOP: begin
          if (rs) begin
            state <= RUN;
          end else if (clr) begin
            state  <= IDLE;
            sw_cnt <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          sw_cnt <= '0;
        end
      endcase
    end
  end

`ifdef SPLIT_EN
  logic        split_hold;
  logic [23:0] split_snap;

  // Snapshot takes the pre-increment value on a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      split_hold <= 1'b0;
      split_snap <= '0;
    end else if (state != RUN || rs) begin
      split_hold <= 1'b0;
    end else if (clr) begin
      split_hold <= ~split_hold;
      if (!split_hold) split_snap <= sw_cnt;
    end
  end

  assign sw_disp = split_hold ? split_snap : sw_cnt;
`else
  assign sw_disp = sw_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      fnd_in_data <= '0;
      sel_display <= 1'b0;
      mode        <= 1'b0;
    end else begin
      fnd_in_data <= mode ? watch : sw_disp;
      if (btn_disp) sel_display <= ~sel_display;
      if (btn_mode) mode <= ~mode;
    end
  end

  assign sw_state = state;

endmodule
